// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches 9-bit instruction words from a synchronous program
// ROM and issues them to the processor over the DIN/Run/Done handshake.
// mvi carries a second ROM word (the immediate). That word is placed on DIN
// after the Run pulse and held until Done is sampled.
//
// Handshake: Run is a single-cycle issue strobe with DIN = instruction word.
// From the next cycle the sequencer holds DIN stable and waits in WAIT_DONE.
// The first cycle in which Done is high completes the instruction. Done is
// ignored in every other state. The watchdog bounds the wait to TIMEOUT
// cycles, and a Done in the expiry cycle still counts as completion.
module instr_sequencer #(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 15
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [8:0]        PData,
  input  logic              Done,
  output logic [ADDR_W-1:0] PAddr,
  output logic [8:0]        DIN,
  output logic              Run,
  output logic              Busy,
  output logic              Finished,
  output logic              Error,
  output logic [7:0]        InstrCount,
  output logic [2:0]        DbgState
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    A_I       = 3'd1,
    D_I       = 3'd2,
    A_M       = 3'd3,
    D_M       = 3'd4,
    ISSUE     = 3'd5,
    WAIT_DONE = 3'd6,
    HALTED    = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [8:0]        ir_q, ir_d;
  logic [8:0]        imm_q, imm_d;
  logic [8:0]        din_q, din_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              eom_q, eom_d;

  logic       pc_at_max;
  logic [2:0] fetch_opc;
  logic       wd_expire;

  assign pc_at_max = (pc_q == {ADDR_W{1'b1}});
  assign fetch_opc = PData[8:6];
  assign wd_expire = (wd_q == WD_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: fetch, decode, issue and completion sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, HALTED: if (Start) state_d = A_I;
      A_I:          state_d = D_I;
      D_I: begin
        if (fetch_opc == 3'b111)      state_d = HALTED;
        else if (fetch_opc[2])        state_d = pc_at_max ? HALTED : A_I;
        else if (fetch_opc == 3'b011) state_d = pc_at_max ? HALTED : A_M;
        else                          state_d = ISSUE;
      end
      A_M:          state_d = D_M;
      D_M:          state_d = ISSUE;
      ISSUE:        state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (Done)           state_d = eom_q ? HALTED : A_I;
        else if (wd_expire) state_d = HALTED;
      end
      default:      state_d = IDLE;
    endcase
  end

  // Output decode from the registered state only
  always_comb begin
    Run      = (state_q == ISSUE);
    Busy     = (state_q != IDLE) && (state_q != HALTED);
    Finished = (state_q == HALTED);
    DbgState = state_q;
  end

  // Datapath next values: PC, IR/IMM latches, DIN, watchdog, counters, flags
  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    imm_d = imm_q;
    din_d = din_q;
    wd_d  = wd_q;
    cnt_d = cnt_q;
    err_d = err_q;
    eom_d = eom_q;
    case (state_q)
      IDLE, HALTED: begin
        if (Start) begin
          pc_d  = '0;
          cnt_d = '0;
          err_d = 1'b0;
          eom_d = 1'b0;
        end
      end
      D_I: begin
        ir_d = PData;
        if (fetch_opc == 3'b111) begin
          // halt: PC stays on the halt word
        end else if (fetch_opc[2]) begin
          if (!pc_at_max) pc_d = pc_q + ADDR_W'(1);
        end else if (fetch_opc == 3'b011) begin
          // mvi needs a following word; none exists past the last address
          if (pc_at_max) err_d = 1'b1;
          else           pc_d  = pc_q + ADDR_W'(1);
        end else begin
          din_d = PData;
          if (pc_at_max) eom_d = 1'b1;
          else           pc_d  = pc_q + ADDR_W'(1);
        end
      end
      D_M: begin
        imm_d = PData;
        din_d = ir_q;
        if (pc_at_max) eom_d = 1'b1;
        else           pc_d  = pc_q + ADDR_W'(1);
      end
      ISSUE: begin
        wd_d  = '0;
        din_d = (ir_q[8:6] == 3'b011) ? imm_q : ir_q;
      end
      WAIT_DONE: begin
        if (Done) begin
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end else if (wd_expire) begin
          err_d = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q  <= '0;
      ir_q  <= '0;
      imm_q <= '0;
      din_q <= '0;
      wd_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      eom_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      imm_q <= imm_d;
      din_q <= din_d;
      wd_q  <= wd_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      eom_q <= eom_d;
    end
  end

  assign PAddr      = pc_q;
  assign DIN        = din_q;
  assign Error      = err_q;
  assign InstrCount = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed and randomized programs for instr_sequencer.
// A program-level reference model walks the ROM contents and the per-
// instruction Done latency to predict every Run (word and cycle), the word
// held on DIN while the processor executes, and the final PC/count/error.
module tb_instr_sequencer;

  localparam int ADDR_W  = 5;
  localparam int TIMEOUT = 15;
  localparam int MEM     = 1 << ADDR_W;
  localparam int BUDGET  = 3000;
  localparam int NEVER   = TIMEOUT + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, start, done;
  logic [8:0]        pdata;
  logic [ADDR_W-1:0] paddr;
  logic [8:0]        din;
  logic              run, busy, finished, error;
  logic [7:0]        instr_count;
  logic [2:0]        dbg_state;

  instr_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .Clock(clk), .Reset(reset), .Start(start), .PData(pdata), .Done(done),
    .PAddr(paddr), .DIN(din), .Run(run), .Busy(busy), .Finished(finished),
    .Error(error), .InstrCount(instr_count), .DbgState(dbg_state)
  );

  // Synchronous program ROM: data valid the cycle after the address
  logic [8:0] rom [MEM];
  always @(posedge clk) pdata <= rom[paddr];

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];       // word expected on DIN with each Run
  int         exp_run_q[$];   // cycle (after Start edge) of each Run
  logic [8:0] exp_post_q[$];  // word expected on DIN while executing
  int         dly [64];       // Done latency per issued instruction
  int         exp_fin_cyc;
  int         exp_pc;
  int         exp_cnt;
  int         exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: walk the program as the sequencer should, counting
  // cycles from the Start edge (cycle 0 is the first address cycle).
  task automatic model_prog();
    int         pc, t, n;
    bit         eom;
    logic [8:0] w, post;
    exp_q.delete(); exp_run_q.delete(); exp_post_q.delete();
    pc = 0; t = 0; n = 0; eom = 0;
    exp_cnt = 0; exp_err = 0;
    while (1) begin
      w = rom[pc];
      t += 2;                                  // address + data cycle
      if (w[8:6] == 3'b111) break;             // halt word
      if (w[8:6] >= 3'b100) begin              // skipped opcode
        if (pc == MEM - 1) break;
        pc++;
        continue;
      end
      if (w[8:6] == 3'b011) begin              // mvi: fetch immediate word
        if (pc == MEM - 1) begin exp_err = 1; break; end
        pc++;
        post = rom[pc];
        t += 2;
      end else begin
        post = w;
      end
      if (pc == MEM - 1) eom = 1;
      else               pc++;
      exp_q.push_back(w);
      exp_run_q.push_back(t);
      exp_post_q.push_back(post);
      if (dly[n] > TIMEOUT) begin              // Done never comes
        exp_err = 1;
        t = t + 1 + TIMEOUT;
        break;
      end
      t = t + dly[n] + 1;
      n++;
      exp_cnt++;
      if (eom) break;
    end
    exp_fin_cyc = t;
    exp_pc      = pc;
  endtask

  // ---------------- driver tasks ----------------
  task automatic fill_rom(input logic [8:0] w);
    for (int i = 0; i < MEM; i++) rom[i] = w;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
  endtask

  // Runs the program in rom[] with Done driven dly[] cycles after each Run.
  // With noise set, Start is pulsed while busy and Done is pulsed outside
  // the wait window; both must be ignored.
  task automatic run_prog(input string name, input bit noise);
    int         c, idx, run_c, done_c, extra;
    bit         fin, in_win;
    logic [8:0] post;
    model_prog();
    idx = 0; run_c = -1; done_c = -1; extra = 0; fin = 0; post = '0;
    pulse_start();
    c = 0;
    while (c < BUDGET) begin
      @(negedge clk);
      start = 1'b0;
      done  = 1'b0;
      if (c == 0) begin
        check({name, "_err_clear"}, error, 0);
        check({name, "_busy_start"}, busy, 1);
      end
      if (finished) begin fin = 1; break; end
      if (run) begin
        if (exp_q.size() == 0) begin
          extra++;
        end else begin
          check({name, "_run_din"}, din, exp_q.pop_front());
          check({name, "_run_cycle"}, c, exp_run_q.pop_front());
          post = exp_post_q.pop_front();
        end
        run_c  = c;
        done_c = (dly[idx] <= TIMEOUT) ? c + dly[idx] : c + 100000;
        idx++;
      end else if (run_c >= 0 && c > run_c && c <= done_c) begin
        check({name, "_din_exec"}, din, post);
      end
      in_win = (run_c >= 0 && c > run_c && c <= done_c);
      if (c == done_c) done = 1'b1;
      else if (noise && !in_win) done = ($urandom_range(0, 3) == 0);
      if (noise) start = ($urandom_range(0, 3) == 0);
      c++;
    end
    start = 1'b0;
    done  = 1'b0;
    check({name, "_finished"}, finished, 1);
    check({name, "_fin_cycle"}, c, exp_fin_cyc);
    check({name, "_pc"}, paddr, exp_pc);
    check({name, "_count"}, instr_count, exp_cnt);
    check({name, "_error"}, error, exp_err);
    check({name, "_busy_end"}, busy, 0);
    check({name, "_runs_missing"}, exp_q.size(), 0);
    check({name, "_runs_extra"}, extra, 0);
  endtask

  function automatic logic [8:0] rand_word();
    int         r;
    logic [2:0] opc;
    r = $urandom_range(0, 15);
    if (r < 4)       opc = 3'b000;
    else if (r < 7)  opc = 3'b001;
    else if (r < 10) opc = 3'b010;
    else if (r < 13) opc = 3'b011;
    else if (r < 15) opc = 3'($urandom_range(4, 6));
    else             opc = 3'b111;
    return {opc, 6'($urandom)};
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    int c, runs, rc;
    reset = 1'b1; start = 1'b0; done = 1'b0;
    fill_rom(9'h1C0);
    for (int i = 0; i < 64; i++) dly[i] = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_paddr", paddr, 0);
    check("rst_din", din, 0);
    check("rst_run", run, 0);
    check("rst_busy", busy, 0);
    check("rst_finished", finished, 0);
    check("rst_error", error, 0);
    check("rst_count", instr_count, 0);
    reset = 1'b0;

    // mv then halt
    fill_rom(9'h1C0);
    rom[0] = 9'h00A; rom[1] = 9'h1C0;
    dly[0] = 1;
    run_prog("mv", 0);

    // add then mvi with immediate
    fill_rom(9'h1C0);
    rom[0] = 9'h05C; rom[1] = 9'h0E8; rom[2] = 9'h0A5; rom[3] = 9'h1C0;
    dly[0] = 3; dly[1] = 2;
    run_prog("add_mvi", 0);

    // skipped opcode
    fill_rom(9'h1C0);
    rom[0] = 9'h100; rom[1] = 9'h00A; rom[2] = 9'h1C0;
    dly[0] = 1;
    run_prog("skip", 0);

    // Done never arrives
    fill_rom(9'h1C0);
    rom[0] = 9'h00A;
    dly[0] = NEVER;
    run_prog("timeout", 0);

    // Done in the watchdog expiry cycle completes normally (also clears Error)
    dly[0] = TIMEOUT;
    run_prog("done_at_expiry", 0);

    // mvi as the last ROM word
    for (int i = 0; i < MEM - 1; i++) rom[i] = {3'($urandom_range(4, 6)), 6'($urandom)};
    rom[MEM-1] = 9'h0C8;
    run_prog("eom_mvi", 0);

    // mv as the last ROM word: completes, then stops without wrapping
    rom[MEM-1] = 9'h051;
    dly[0] = 2;
    run_prog("eom_mv", 0);

    // mvi whose immediate is the last ROM word
    rom[MEM-2] = 9'h0D0; rom[MEM-1] = 9'h1FF;
    dly[0] = 4;
    run_prog("eom_imm", 0);

    // random programs with Start/Done noise
    for (int k = 0; k < 25; k++) begin
      for (int i = 0; i < MEM; i++) rom[i] = rand_word();
      for (int i = 0; i < 64; i++)
        dly[i] = ($urandom_range(0, 11) == 0) ? NEVER : $urandom_range(1, TIMEOUT);
      run_prog("rand", 1);
    end

    // Reset in the middle of waiting for Done
    fill_rom(9'h1C0);
    rom[0] = 9'h00A; rom[1] = 9'h051; rom[2] = 9'h1C0;
    pulse_start();
    c = 0; runs = 0; rc = 0;
    while (c < 200 && runs < 2) begin
      @(negedge clk);
      start = 1'b0;
      done  = 1'b0;
      if (run) begin runs++; rc = c; end
      else if (runs == 1 && c == rc + 1) done = 1'b1;
      c++;
    end
    check("rstmid_runs", runs, 2);
    @(negedge clk);
    check("rstmid_pre_count", instr_count, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_run", run, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_count", instr_count, 0);
    check("rstmid_paddr", paddr, 0);
    check("rstmid_din", din, 0);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    check("late_done_count", instr_count, 0);
    check("late_done_busy", busy, 0);
    check("late_done_finished", finished, 0);
    check("late_done_run", run, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
